// File: rtl/multiword_addsub_sequencer_pkg.sv
// Shared types and constants for the chunk-serial add/subtract sequencer.
package multiword_addsub_sequencer_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } seq_state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Chunk index width; a single-chunk configuration still gets a 1-bit index.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/multiword_addsub_sequencer_if.sv
// Request/result handshake bundle between operand source, sequencer and consumer.
interface multiword_addsub_sequencer_if #(
    parameter int unsigned OPERAND_WIDTH = 64
);
    logic                     in_valid;
    logic                     in_ready;
    logic [OPERAND_WIDTH-1:0] A;
    logic [OPERAND_WIDTH-1:0] B;
    logic                     op;
    logic                     Cin;
    logic                     out_valid;
    logic                     out_ready;
    logic [OPERAND_WIDTH-1:0] S;
    logic                     CF;
    logic                     OF;

    modport master (
        output in_valid, A, B, op, Cin, out_ready,
        input  in_ready, out_valid, S, CF, OF
    );

    modport slave (
        input  in_valid, A, B, op, Cin, out_ready,
        output in_ready, out_valid, S, CF, OF
    );
endinterface

// File: rtl/carry_bypass_adder.sv
// Combinational adder whose carry skips any block where every bit propagates.
module carry_bypass_adder #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned BLOCK_SIZE = 4
) (
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    input  logic                  Cin,
    output logic [DATA_WIDTH-1:0] S,
    output logic                  CF,
    output logic                  OF
);
    localparam int unsigned NumBlocks = DATA_WIDTH / BLOCK_SIZE;

    logic [DATA_WIDTH-1:0] p;
    logic [DATA_WIDTH-1:0] g;
    logic                  c;
    logic                  blk_cin;
    logic                  c_msb;

    assign p = A ^ B;
    assign g = A & B;

    always_comb begin
        S       = '0;
        c       = Cin;
        blk_cin = Cin;
        c_msb   = 1'b0;
        for (int blk = 0; blk < int'(NumBlocks); blk++) begin
            blk_cin = c;
            for (int i = 0; i < int'(BLOCK_SIZE); i++) begin
                if (blk * int'(BLOCK_SIZE) + i == int'(DATA_WIDTH) - 1) c_msb = c;
                S[blk*BLOCK_SIZE+i] = p[blk*BLOCK_SIZE+i] ^ c;
                c = g[blk*BLOCK_SIZE+i] | (p[blk*BLOCK_SIZE+i] & c);
            end
            if (&p[blk*BLOCK_SIZE +: BLOCK_SIZE]) c = blk_cin;
        end
        CF = c;
        OF = c_msb ^ c;
    end

endmodule

// File: rtl/multiword_addsub_sequencer.sv
// Wide add/subtract computed least-significant chunk first through one shared narrow adder.
module multiword_addsub_sequencer
    import multiword_addsub_sequencer_pkg::*;
#(
    parameter int unsigned OPERAND_WIDTH = 64,
    parameter int unsigned CHUNK_WIDTH   = 16,
    parameter int unsigned BLOCK_SIZE    = 4
) (
    input logic                        clk,
    input logic                        rst_n,
    multiword_addsub_sequencer_if.slave bus
);
    localparam int unsigned N  = OPERAND_WIDTH / CHUNK_WIDTH;
    localparam int unsigned KW = idx_width(N);
    localparam logic [KW-1:0] LastChunk = KW'(N - 1);

    if ((OPERAND_WIDTH % CHUNK_WIDTH) != 0 || (CHUNK_WIDTH % BLOCK_SIZE) != 0 || N == 0) begin
        $error("OPERAND_WIDTH/CHUNK_WIDTH/BLOCK_SIZE divisibility violated");
    end

    seq_state_e                   state_q;
    logic [KW-1:0]                k_q;
    logic                         carry_q;
    logic [N-1:0][CHUNK_WIDTH-1:0] a_q;
    logic [N-1:0][CHUNK_WIDTH-1:0] b_q;
    logic [N-1:0][CHUNK_WIDTH-1:0] s_q;
    logic                         cf_q;
    logic                         of_q;
    logic                         in_ready_q;
    logic                         out_valid_q;

    logic [CHUNK_WIDTH-1:0] sum;
    logic                   add_cf;
    logic                   add_of;

    carry_bypass_adder #(
        .DATA_WIDTH(CHUNK_WIDTH),
        .BLOCK_SIZE(BLOCK_SIZE)
    ) u_adder (
        .A  (a_q[k_q]),
        .B  (b_q[k_q]),
        .Cin(carry_q),
        .S  (sum),
        .CF (add_cf),
        .OF (add_of)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            k_q         <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            s_q         <= '0;
            cf_q        <= 1'b0;
            of_q        <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        a_q        <= bus.A;
                        // Subtract is A + ~B + 1, so the +1 rides in on the carry.
                        b_q        <= (bus.op == OP_SUB) ? ~bus.B : bus.B;
                        carry_q    <= (bus.op == OP_SUB) ? 1'b1 : bus.Cin;
                        k_q        <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= StRun;
                    end
                end
                StRun: begin
                    s_q[k_q] <= sum;
                    carry_q  <= add_cf;
                    if (k_q == LastChunk) begin
                        cf_q        <= add_cf;
                        of_q        <= add_of;
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                StDone: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.S         = s_q;
    assign bus.CF        = cf_q;
    assign bus.OF        = of_q;

endmodule

// File: tb/tb_multiword_addsub_sequencer.sv
// Self-checking bench: vector table, random ops against an arithmetic model, corner sequences.
module tb_multiword_addsub_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    multiword_addsub_sequencer_if #(.OPERAND_WIDTH(64)) bus ();
    multiword_addsub_sequencer_if #(.OPERAND_WIDTH(16)) bus1 ();

    multiword_addsub_sequencer #(
        .OPERAND_WIDTH(64),
        .CHUNK_WIDTH  (16),
        .BLOCK_SIZE   (4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    multiword_addsub_sequencer #(
        .OPERAND_WIDTH(16),
        .CHUNK_WIDTH  (16),
        .BLOCK_SIZE   (4)
    ) dut1 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus1)
    );

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        op;
        logic        cin;
        logic [63:0] s;
        logic        cf;
        logic        of;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic; OF means the signed result does not fit in 64 bits.
    function automatic void model(input logic [63:0] a, input logic [63:0] b, input logic op,
                                  input logic cin, output logic [63:0] s, output logic cf,
                                  output logic of);
        logic [64:0]        u;
        logic signed [65:0] sa;
        logic signed [65:0] sb;
        logic signed [65:0] sr;
        sa = $signed({{2{a[63]}}, a});
        sb = $signed({{2{b[63]}}, b});
        if (op) begin
            u  = {1'b0, a} - {1'b0, b};
            cf = (a >= b);
            sr = sa - sb;
        end else begin
            u  = {1'b0, a} + {1'b0, b} + {64'b0, cin};
            cf = u[64];
            sr = sa + sb + $signed({65'b0, cin});
        end
        s  = u[63:0];
        of = (sr[65:63] != {3{sr[63]}});
    endfunction

    task automatic do_op(input logic [63:0] a, input logic [63:0] b, input logic op,
                         input logic cin, output logic [63:0] s, output logic cf,
                         output logic of, output int lat);
        check("in_ready_before_accept", 64'(bus.in_ready), 64'(1));
        bus.A        = a;
        bus.B        = b;
        bus.op       = op;
        bus.Cin      = cin;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.A        = {$urandom, $urandom};
        bus.B        = {$urandom, $urandom};
        bus.op       = 1'($urandom);
        bus.Cin      = 1'($urandom);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            tick();
            lat++;
        end
        s  = bus.S;
        cf = bus.CF;
        of = bus.OF;
        check("in_ready_in_done", 64'(bus.in_ready), 64'(0));
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("out_valid_after_release", 64'(bus.out_valid), 64'(0));
    endtask

    initial begin
        logic [63:0] s;
        logic        cf;
        logic        of;
        int          lat;
        logic [63:0] ms;
        logic        mcf;
        logic        mof;

        vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0};
        vecs[1] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
        vecs[2] = '{64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
        vecs[3] = '{64'h5, 64'h7, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
        vecs[4] = '{64'h3, 64'h4, 1'b0, 1'b1, 64'h8, 1'b0, 1'b0};
        vecs[5] = '{64'h1_0000, 64'hFFFF, 1'b0, 1'b0, 64'h1_FFFF, 1'b0, 1'b0};
        vecs[6] = '{64'h0, 64'h0, 1'b0, 1'b1, 64'h1, 1'b0, 1'b0};
        vecs[7] = '{64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0};

        rst_n          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.A          = '0;
        bus.B          = '0;
        bus.op         = 1'b0;
        bus.Cin        = 1'b0;
        bus.out_ready  = 1'b0;
        bus1.in_valid  = 1'b0;
        bus1.A         = '0;
        bus1.B         = '0;
        bus1.op        = 1'b0;
        bus1.Cin       = 1'b0;
        bus1.out_ready = 1'b0;
        repeat (2) tick();

        check("reset_in_ready", 64'(bus.in_ready), 64'(1));
        check("reset_out_valid", 64'(bus.out_valid), 64'(0));
        check("reset_S", bus.S, 64'h0);
        check("reset_CF", 64'(bus.CF), 64'(0));
        check("reset_OF", 64'(bus.OF), 64'(0));
        check("reset_n1_in_ready", 64'(bus1.in_ready), 64'(1));
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].cin, s, cf, of, lat);
            check($sformatf("vec%0d_S", i), s, vecs[i].s);
            check($sformatf("vec%0d_CF", i), 64'(cf), 64'(vecs[i].cf));
            check($sformatf("vec%0d_OF", i), 64'(of), 64'(vecs[i].of));
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(4));
        end

        for (int i = 0; i < 30; i++) begin
            logic [63:0] ra;
            logic [63:0] rb;
            logic        rop;
            logic        rcin;
            ra   = {$urandom, $urandom};
            rb   = (i % 5 == 0) ? ra : {$urandom, $urandom};
            rop  = 1'($urandom);
            rcin = 1'($urandom);
            model(ra, rb, rop, rcin, ms, mcf, mof);
            do_op(ra, rb, rop, rcin, s, cf, of, lat);
            check($sformatf("rand%0d_S", i), s, ms);
            check($sformatf("rand%0d_CF", i), 64'(cf), 64'(mcf));
            check($sformatf("rand%0d_OF", i), 64'(of), 64'(mof));
            check($sformatf("rand%0d_latency", i), 64'(lat), 64'(4));
        end

        // Backpressure: result held, requests ignored while DONE.
        bus.A = 64'h3;
        bus.B = 64'h4;
        bus.op = 1'b0;
        bus.Cin = 1'b1;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("bp_latency", 64'(lat), 64'(4));
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.A = {$urandom, $urandom};
            tick();
            check("bp_S_stable", bus.S, 64'h8);
            check("bp_out_valid", 64'(bus.out_valid), 64'(1));
            check("bp_in_ready", 64'(bus.in_ready), 64'(0));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("bp_release_out_valid", 64'(bus.out_valid), 64'(0));
        check("bp_release_in_ready", 64'(bus.in_ready), 64'(1));
        tick();
        check("bp_no_extra_accept", 64'(bus.in_ready), 64'(1));

        // Reset mid-operation after leaving a CF=1 result behind.
        do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, s, cf, of, lat);
        bus.A = 64'hFFFF_FFFF_FFFF_FFFF;
        bus.B = 64'hFFFF_FFFF_FFFF_FFFF;
        bus.op = 1'b0;
        bus.Cin = 1'b1;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (2) tick();
        rst_n = 1'b0;
        tick();
        check("rst_mid_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_mid_S", bus.S, 64'h0);
        check("rst_mid_CF", 64'(bus.CF), 64'(0));
        rst_n = 1'b1;
        tick();
        check("rst_mid_in_ready", 64'(bus.in_ready), 64'(1));
        do_op(64'h1_0000, 64'hFFFF, 1'b0, 1'b0, s, cf, of, lat);
        check("post_rst_S", s, 64'h1_FFFF);
        check("post_rst_latency", 64'(lat), 64'(4));

        // Single-chunk configuration.
        check("n1_in_ready", 64'(bus1.in_ready), 64'(1));
        bus1.A = 16'hFFFF;
        bus1.B = 16'h0001;
        bus1.op = 1'b0;
        bus1.Cin = 1'b0;
        bus1.in_valid = 1'b1;
        tick();
        bus1.in_valid = 1'b0;
        lat = 0;
        while (!bus1.out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("n1_latency", 64'(lat), 64'(1));
        check("n1_S", 64'(bus1.S), 64'h0);
        check("n1_CF", 64'(bus1.CF), 64'(1));
        check("n1_OF", 64'(bus1.OF), 64'(0));
        bus1.out_ready = 1'b1;
        tick();
        bus1.out_ready = 1'b0;
        check("n1_release", 64'(bus1.out_valid), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
